// File: rtl/key_onehot_debounce.sv
// key_onehot_debounce
//   Turns four raw, bouncing, asynchronous key lines into a registered one-hot
//   key code for a downstream 4-to-2 encoder. Each line is synchronised,
//   debounced and edge-detected. Simultaneous rises are arbitrated with the
//   lowest index winning. After a press is accepted, further presses are locked
//   out until every key has been released.
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   btn[3:0]     raw key lines, active high (bit0=a .. bit3=d)
//   clear        synchronous clear of the latched code
//   a, b, c, d   registered one-hot code of the last accepted key
//   press_valid  one-cycle strobe in the cycle the code updates
//   key_held     high while a key press is being held (lockout)
module key_onehot_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn,
    input  logic       clear,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       press_valid,
    output logic       key_held
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StHeld} state_e;

    logic [3:0]           sync1_q, sync2_q;
    logic [3:0]           deb_q, deb_d;
    logic [3:0]           deb_dly_q;
    logic [3:0][CntW-1:0] cnt_q, cnt_d;
    logic [3:0]           rise;
    logic [3:0]           winner;
    logic [3:0]           code_q, code_d;
    logic                 pv_q, pv_d;
    state_e               state_q, state_d;

    // Debounce: a new level must persist for DEBOUNCE_CYCLES consecutive
    // synchronised samples; any sample back at the old level restarts the count.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    assign rise = deb_q & ~deb_dly_q;

    // Fixed priority, key a highest. Losing rises are simply dropped.
    always_comb begin
        winner = 4'b0000;
        if (rise[0]) begin
            winner = 4'b0001;
        end else if (rise[1]) begin
            winner = 4'b0010;
        end else if (rise[2]) begin
            winner = 4'b0100;
        end else if (rise[3]) begin
            winner = 4'b1000;
        end
    end

    // An accepted press overrides a clear in the same cycle.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        pv_d    = 1'b0;
        if (clear) begin
            code_d = 4'b0000;
        end
        unique case (state_q)
            StIdle: begin
                if (|rise) begin
                    code_d  = winner;
                    pv_d    = 1'b1;
                    state_d = StHeld;
                end
            end
            StHeld: begin
                if (deb_q == 4'b0000) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            cnt_q     <= '0;
            code_q    <= '0;
            pv_q      <= 1'b0;
            state_q   <= StIdle;
        end else begin
            sync1_q   <= btn;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            pv_q      <= pv_d;
            state_q   <= state_d;
        end
    end

    assign a           = code_q[0];
    assign b           = code_q[1];
    assign c           = code_q[2];
    assign d           = code_q[3];
    assign press_valid = pv_q;
    assign key_held    = (state_q == StHeld);

endmodule

// File: tb/tb_key_onehot_debounce.sv
// Self-checking bench for key_onehot_debounce: directed scenarios with fixed
// expected latencies plus randomized key/clear traffic, all checked against a
// behavioural model built on a per-key sample history.
module tb_key_onehot_debounce;

    localparam int unsigned N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn = 4'b0000;
    logic       clear = 1'b0;
    logic       a, b, c, d, press_valid, key_held;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    bit          mon_on = 1'b0;

    key_onehot_debounce #(.DEBOUNCE_CYCLES(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (btn),
        .clear      (clear),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .press_valid(press_valid),
        .key_held   (key_held)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model. bh[i][j] holds the raw sample of key i taken j+1 edges
    // ago. The synchronised value seen at an edge is the raw sample from two
    // edges earlier, so the debounced level flips once the last N synchronised
    // samples all disagree with it.
    logic [15:0] bh [4];
    logic [3:0]  m_deb = '0, m_deb_q = '0, m_code = '0, m_rise, m_nd;
    logic        m_pv = 1'b0, m_held = 1'b0;
    bit          all_diff;

    initial for (int i = 0; i < 4; i++) bh[i] = '0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_deb = '0; m_deb_q = '0; m_code = '0; m_pv = 1'b0; m_held = 1'b0;
            for (int i = 0; i < 4; i++) bh[i] = '0;
        end else begin
            m_rise = m_deb & ~m_deb_q;
            m_pv = 1'b0;
            if (clear) m_code = 4'b0000;
            if (!m_held) begin
                if (m_rise != 4'b0000) begin
                    m_code = m_rise & (~m_rise + 4'd1);  // lowest set bit
                    m_pv   = 1'b1;
                    m_held = 1'b1;
                end
            end else if (m_deb == 4'b0000) begin
                m_held = 1'b0;
            end
            m_nd = m_deb;
            for (int i = 0; i < 4; i++) begin
                all_diff = 1'b1;
                for (int j = 1; j <= int'(N); j++) if (bh[i][j] == m_deb[i]) all_diff = 1'b0;
                if (all_diff) m_nd[i] = ~m_deb[i];
                bh[i] = {bh[i][14:0], btn[i]};
            end
            m_deb_q = m_deb;
            m_deb   = m_nd;
        end
    end

    initial forever begin
        @(negedge clk);
        if (mon_on && rst_n) begin
            check("model_code", {d, c, b, a}, m_code);
            check("model_pv", press_valid, m_pv);
            check("model_held", key_held, m_held);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Counts rising edges until press_valid is seen; 99 means it never came.
    task automatic wait_pv(output int unsigned n);
        bit seen = 1'b0;
        n = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (press_valid) seen = 1'b1;
        end
        if (!seen) n = 99;
    endtask

    task automatic wait_release(output int unsigned n);
        bit gone = 1'b0;
        n = 0;
        for (int k = 0; k < 30 && !gone; k++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!key_held) gone = 1'b1;
        end
        if (!gone) n = 99;
    endtask

    int unsigned n, pv_cnt, hold_len;
    int unsigned bounce_lat;
    logic [7:0]  pat;

    initial begin
        repeat (3) tick();
        check("rst_code", {d, c, b, a}, 0);
        check("rst_pv", press_valid, 0);
        check("rst_held", key_held, 0);
        rst_n  = 1'b1;
        mon_on = 1'b1;
        repeat (3) tick();

        // Clean press of key b, then release.
        btn = 4'b0010;
        wait_pv(n);
        check("clean_lat", n, 7);
        check("clean_code", {d, c, b, a}, 4'b0010);
        tick();
        check("clean_pv_once", press_valid, 0);
        check("clean_held", key_held, 1);
        repeat (5) tick();
        btn = 4'b0000;
        wait_release(n);
        check("release_lat", n, 7);
        check("release_code_kept", {d, c, b, a}, 4'b0010);
        repeat (4) tick();

        // Bouncing key a: 1,1,1,0,1,1,1,1 then stays high.
        pat = 8'b1111_0111;
        bounce_lat = 99;
        for (int i = 0; i < 20; i++) begin
            btn[0] = (i < 8) ? pat[i] : 1'b1;
            tick();
            if (press_valid && bounce_lat == 99) bounce_lat = i + 1;
        end
        check("bounce_lat", bounce_lat, 11);
        check("bounce_code", {d, c, b, a}, 4'b0001);
        btn = 4'b0000;
        repeat (12) tick();

        // Simultaneous b+d: b wins, then lockout of a, then d alone.
        btn = 4'b1010;
        pv_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (press_valid) pv_cnt++;
        end
        check("simul_pv_count", pv_cnt, 1);
        check("simul_code", {d, c, b, a}, 4'b0010);
        btn = 4'b1011;
        pv_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (press_valid) pv_cnt++;
        end
        check("lockout_pv_count", pv_cnt, 0);
        check("lockout_code", {d, c, b, a}, 4'b0010);
        btn = 4'b0000;
        repeat (12) tick();
        check("all_released", key_held, 0);
        btn = 4'b1000;
        wait_pv(n);
        check("d_lat", n, 7);
        check("d_code", {d, c, b, a}, 4'b1000);
        btn = 4'b0000;
        repeat (12) tick();

        // Clear sampled on the same edge that accepts a press of c.
        btn = 4'b0100;
        repeat (6) tick();
        check("collide_pre_pv", press_valid, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("collide_pv", press_valid, 1);
        check("collide_code", {d, c, b, a}, 4'b0100);
        repeat (3) tick();

        // Clear on its own while c is still held.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_code", {d, c, b, a}, 0);
        check("clear_held", key_held, 1);
        check("clear_pv", press_valid, 0);
        repeat (2) tick();

        // Asynchronous reset mid-cycle with c held, then fresh press after release.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("amid_rst_code", {d, c, b, a}, 0);
        check("amid_rst_pv", press_valid, 0);
        check("amid_rst_held", key_held, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_pv(n);
        check("post_rst_lat", n, 7);
        check("post_rst_code", {d, c, b, a}, 4'b0100);
        btn = 4'b0000;
        repeat (12) tick();

        // Randomized traffic with bounces and occasional clears.
        for (int seg = 0; seg < 400; seg++) begin
            btn = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
            hold_len = $urandom_range(1, 12);
            for (int k = 0; k < int'(hold_len); k++) begin
                clear = ($urandom_range(0, 15) == 0);
                tick();
            end
        end
        clear = 1'b0;
        btn   = 4'b0000;
        repeat (12) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
